// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer datapath: address width,
// timing-signal indices and opcode-decode indices.
package mano_pkg;

    localparam int AW_DEFAULT = 12;

    localparam int T0_IDX = 0;
    localparam int T1_IDX = 1;
    localparam int T2_IDX = 2;
    localparam int T3_IDX = 3;
    localparam int T4_IDX = 4;
    localparam int T5_IDX = 5;
    localparam int T6_IDX = 6;
    localparam int T7_IDX = 7;

    localparam int OP_AND = 0;
    localparam int OP_ADD = 1;
    localparam int OP_LDA = 2;
    localparam int OP_STA = 3;
    localparam int OP_BUN = 4;
    localparam int OP_BSA = 5;
    localparam int OP_ISZ = 6;
    localparam int OP_REG = 7;
    // D7 decodes both register-reference and IO instructions.
    localparam int OP_RIO = OP_REG;

endpackage

// File: rtl/mano_pc_ctrl.sv
// Raw PC micro-operation requests decoded from timing, opcode and interrupt state.
module mano_pc_ctrl
    import mano_pkg::*;
(
    input  logic [7:0] T,
    input  logic [7:0] D,
    input  logic       R,
    input  logic       skip,
    input  logic       run,
    output logic       ld_req,
    output logic       inc_req,
    output logic       clr_req,
    output logic       multi_req
);

    logic inc_raw;
    logic ld_raw;
    logic clr_raw;

    always_comb begin
        inc_raw = (~R & T[T1_IDX])
                | ( R & T[T2_IDX])
                | (D[OP_ISZ] & T[T6_IDX] & skip)
                | (D[OP_RIO] & T[T3_IDX] & skip);
        ld_raw  = (D[OP_BUN] & T[T4_IDX])
                | (D[OP_BSA] & T[T5_IDX]);
        clr_raw = R & T[T1_IDX];

        // A halted machine issues nothing, so it can neither move PC nor flag an error.
        inc_req   = run & inc_raw;
        ld_req    = run & ld_raw;
        clr_req   = run & clr_raw;
        multi_req = (inc_req & ld_req) | (inc_req & clr_req) | (ld_req & clr_req);
    end

endmodule

// File: rtl/mano_pc_unit.sv
// Mano program counter: PC register, clr > ld > inc strobe priority and a
// sticky flag for cycles that requested more than one PC operation.
module mano_pc_unit
    import mano_pkg::*;
#(
    parameter int          AW        = AW_DEFAULT,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter logic [AW-1:0] INT_VEC   = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [7:0]    T,
    input  logic [7:0]    D,
    input  logic          I,
    input  logic          R,
    input  logic          skip,
    input  logic [AW-1:0] ar_in,
    output logic [AW-1:0] pc_out,
    output logic          ld,
    output logic          inc,
    output logic          clr,
    output logic          ctrl_err
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic          err_q;
    logic          err_d;
    logic          ld_req;
    logic          inc_req;
    logic          clr_req;
    logic          multi_req;

    // skip arrives already qualified by I, so I plays no part in the PC equations.
    logic unused_i;
    assign unused_i = I;

    mano_pc_ctrl u_ctrl (
        .T         (T),
        .D         (D),
        .R         (R),
        .skip      (skip),
        .run       (run),
        .ld_req    (ld_req),
        .inc_req   (inc_req),
        .clr_req   (clr_req),
        .multi_req (multi_req)
    );

    always_comb begin
        clr   = clr_req;
        ld    = ld_req & ~clr_req;
        inc   = inc_req & ~clr_req & ~ld_req;
        pc_d  = pc_q;
        err_d = err_q | multi_req;
        if (clr) begin
            pc_d = INT_VEC;
        end else if (ld) begin
            pc_d = ar_in;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc_out   = pc_q;
    assign ctrl_err = err_q;

endmodule

// File: tb/tb_mano_pc_unit.sv
// Directed bench for mano_pc_unit: strobes checked in the drive cycle, the
// resulting PC pushed to a queue and popped one edge later.
module tb_mano_pc_unit;

    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic          run;
    logic [7:0]    T;
    logic [7:0]    D;
    logic          I;
    logic          R;
    logic          skip;
    logic [AW-1:0] ar_in;
    logic [AW-1:0] pc_out;
    logic          ld;
    logic          inc;
    logic          clr;
    logic          ctrl_err;

    logic [AW-1:0] exp_q[$];
    int            n_tests;
    int            n_fail;

    mano_pc_unit #(.AW(AW), .RESET_VEC(12'h000), .INT_VEC(12'h000)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .T        (T),
        .D        (D),
        .I        (I),
        .R        (R),
        .skip     (skip),
        .ar_in    (ar_in),
        .pc_out   (pc_out),
        .ld       (ld),
        .inc      (inc),
        .clr      (clr),
        .ctrl_err (ctrl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_pc(input string tag);
        logic [AW-1:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s observed=%03h expected=<empty queue>", tag, pc_out);
        end else begin
            exp = exp_q.pop_front();
            assert (pc_out === exp) else begin
                n_fail++;
                $error("FAIL %s observed=%03h expected=%03h", tag, pc_out, exp);
            end
        end
    endtask

    // Drive one cycle; exp_s is {clr, ld, inc}. Inputs change 1 time unit after a rising edge.
    task automatic step(input string tag, input logic [7:0] t, input logic [7:0] d,
                        input logic r, input logic sk, input logic i,
                        input logic [AW-1:0] ar, input logic [2:0] exp_s,
                        input logic [AW-1:0] exp_pc);
        T = t; D = d; R = r; skip = sk; I = i; ar_in = ar;
        #2;
        n_tests++;
        assert ({clr, ld, inc} === exp_s) else begin
            n_fail++;
            $error("FAIL %s_strobe observed=%03b expected=%03b", tag, {clr, ld, inc}, exp_s);
        end
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #1;
        check_pc({tag, "_pc"});
    endtask

    task automatic load_pc(input logic [AW-1:0] v);
        step("preload", 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, v, 3'b010, v);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        T = '0; D = '0; R = 1'b0; skip = 1'b0; I = 1'b0; ar_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        run     = 1'b0;
        do_reset();
        exp_q.push_back(12'h000);
        check_pc("reset_pc");
        check_bit("reset_err", ctrl_err, 1'b0);
        run = 1'b1;

        // Fetch increment
        step("fetch_t1", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 3'b001, 12'h001);

        // BUN taken at T4, ignored at T3
        load_pc(12'h010);
        step("bun_t4", 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 12'h3A5, 3'b010, 12'h3A5);
        load_pc(12'h010);
        step("bun_t3", 8'h08, 8'h10, 1'b0, 1'b0, 1'b0, 12'h3A5, 3'b000, 12'h010);

        // BSA: hold at T4, load incremented AR at T5
        load_pc(12'h020);
        step("bsa_t4", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 12'h100, 3'b000, 12'h020);
        step("bsa_t5", 8'h20, 8'h20, 1'b0, 1'b0, 1'b0, 12'h101, 3'b010, 12'h101);

        // ISZ and register/IO skips
        load_pc(12'h050);
        step("isz_skip",   8'h40, 8'h40, 1'b0, 1'b1, 1'b0, 12'h000, 3'b001, 12'h051);
        step("isz_noskip", 8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 12'h000, 3'b000, 12'h051);
        step("io_skip",    8'h08, 8'h80, 1'b0, 1'b1, 1'b1, 12'h000, 3'b001, 12'h052);
        step("rr_noskip",  8'h08, 8'h80, 1'b0, 1'b0, 1'b0, 12'h000, 3'b000, 12'h052);

        // Interrupt cycle
        load_pc(12'h123);
        step("int_t1", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 12'h777, 3'b100, 12'h000);
        step("int_t2", 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 12'h777, 3'b001, 12'h001);

        // Wrap, idle inputs and halt
        load_pc(12'hFFF);
        step("wrap", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 3'b001, 12'h000);
        step("idle", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 12'h555, 3'b000, 12'h000);
        run = 1'b0;
        step("halt_t1",  8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 3'b000, 12'h000);
        step("halt_bad", 8'h12, 8'h10, 1'b0, 1'b0, 1'b0, 12'h2B4, 3'b000, 12'h000);
        check_bit("halt_err", ctrl_err, 1'b0);
        run = 1'b1;

        // Malformed T: ld beats inc, error becomes sticky until reset
        step("multi", 8'h12, 8'h10, 1'b0, 1'b0, 1'b0, 12'h2B4, 3'b010, 12'h2B4);
        check_bit("err_set", ctrl_err, 1'b1);
        step("after_multi", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 3'b000, 12'h2B4);
        check_bit("err_sticky", ctrl_err, 1'b1);

        // Reset overrides a pending strobe
        T = 8'h02; D = 8'h00; R = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; T = 8'h00;
        exp_q.push_back(12'h000);
        check_pc("rst_mid_pc");
        check_bit("rst_mid_err", ctrl_err, 1'b0);

        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
